// File: rtl/dsa_interp_sequencer.sv
// Raster-order sequencer for the bilinear scaler: gathers four source neighbours
// per output pixel, launches one dsa_datapath interpolation, writes back the result.
`timescale 1ns/1ps
module dsa_interp_sequencer #(
  parameter int DIM_W  = 10,
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIM_W-1:0]  in_w,
  input  logic [DIM_W-1:0]  in_h,
  input  logic [DIM_W-1:0]  out_w,
  input  logic [DIM_W-1:0]  out_h,
  input  logic [15:0]       step,
  output logic [ADDR_W-1:0] src_addr,
  output logic              src_rd,
  input  logic [7:0]        src_data,
  output logic [ADDR_W-1:0] dst_addr,
  output logic              dst_we,
  output logic [7:0]        dst_data,
  output logic              dp_start,
  output logic [7:0]        dp_p00,
  output logic [7:0]        dp_p01,
  output logic [7:0]        dp_p10,
  output logic [7:0]        dp_p11,
  output logic [15:0]       dp_a,
  output logic [15:0]       dp_b,
  input  logic [7:0]        dp_pixel,
  input  logic              dp_done,
  output logic              busy,
  output logic              done
);

  localparam int ACC_W = DIM_W + 8;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_CAPT, S_LAUNCH, S_WAIT_DP, S_WRITE, S_FIN
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          fcnt_q;
  logic [DIM_W-1:0]    in_w_q, in_h_q, out_w_q, out_h_q;
  logic [15:0]         step_q;
  logic [ACC_W-1:0]    x_acc_q, y_acc_q;
  logic [DIM_W-1:0]    x_out_q, y_out_q;
  logic [ADDR_W-1:0]   out_idx_q;
  logic [3:0][7:0]     nbr_q;
  logic [7:0]          pix_q;
  logic                done_q;

  // Integer coordinates, clamped so reads never leave the source image
  logic [DIM_W-1:0] w_max, h_max, xi_raw, yi_raw, xi, yi, xi1, yi1, col, row;
  logic             last_x, last_y;

  always_comb begin
    w_max  = in_w_q - DIM_W'(1);
    h_max  = in_h_q - DIM_W'(1);
    xi_raw = x_acc_q[ACC_W-1:8];
    yi_raw = y_acc_q[ACC_W-1:8];
    xi     = (xi_raw > w_max) ? w_max : xi_raw;
    yi     = (yi_raw > h_max) ? h_max : yi_raw;
    xi1    = (xi >= w_max) ? w_max : xi + DIM_W'(1);
    yi1    = (yi >= h_max) ? h_max : yi + DIM_W'(1);
    // fcnt bit0 selects column +1, bit1 selects row +1: order p00,p01,p10,p11
    col    = fcnt_q[0] ? xi1 : xi;
    row    = fcnt_q[1] ? yi1 : yi;
    last_x = (x_out_q == out_w_q - DIM_W'(1));
    last_y = (y_out_q == out_h_q - DIM_W'(1));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = (out_w == '0 || out_h == '0) ? S_FIN : S_FETCH;
      S_FETCH:   if (fcnt_q == 2'd3) state_d = S_CAPT;
      S_CAPT:    state_d = S_LAUNCH;
      S_LAUNCH:  state_d = S_WAIT_DP;
      S_WAIT_DP: if (dp_done) state_d = S_WRITE;
      S_WRITE:   state_d = (last_x && last_y) ? S_FIN : S_FETCH;
      S_FIN:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      fcnt_q    <= '0;
      in_w_q    <= '0;
      in_h_q    <= '0;
      out_w_q   <= '0;
      out_h_q   <= '0;
      step_q    <= '0;
      x_acc_q   <= '0;
      y_acc_q   <= '0;
      x_out_q   <= '0;
      y_out_q   <= '0;
      out_idx_q <= '0;
      nbr_q     <= '0;
      pix_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == S_FIN);
      case (state_q)
        S_IDLE: if (start) begin
          in_w_q    <= in_w;
          in_h_q    <= in_h;
          out_w_q   <= out_w;
          out_h_q   <= out_h;
          step_q    <= step;
          x_acc_q   <= '0;
          y_acc_q   <= '0;
          x_out_q   <= '0;
          y_out_q   <= '0;
          out_idx_q <= '0;
          fcnt_q    <= '0;
        end
        S_FETCH: begin
          fcnt_q <= fcnt_q + 2'd1;
          // read data lags the strobe by one cycle
          if (fcnt_q != 2'd0) nbr_q[fcnt_q - 2'd1] <= src_data;
        end
        S_CAPT:    nbr_q[3] <= src_data;
        S_WAIT_DP: if (dp_done) pix_q <= dp_pixel;
        S_WRITE: begin
          out_idx_q <= out_idx_q + ADDR_W'(1);
          if (last_x) begin
            x_out_q <= '0;
            x_acc_q <= '0;
            y_out_q <= y_out_q + DIM_W'(1);
            y_acc_q <= y_acc_q + ACC_W'(step_q);
          end else begin
            x_out_q <= x_out_q + DIM_W'(1);
            x_acc_q <= x_acc_q + ACC_W'(step_q);
          end
        end
        default: ;
      endcase
    end
  end

  logic [ADDR_W-1:0] lin;
  assign lin = ADDR_W'(row) * ADDR_W'(in_w_q) + ADDR_W'(col);

  assign src_rd   = (state_q == S_FETCH);
  assign src_addr = src_rd ? lin : '0;
  assign dst_we   = (state_q == S_WRITE);
  assign dst_addr = out_idx_q;
  assign dst_data = pix_q;
  assign dp_start = (state_q == S_LAUNCH);
  assign dp_p00   = nbr_q[0];
  assign dp_p01   = nbr_q[1];
  assign dp_p10   = nbr_q[2];
  assign dp_p11   = nbr_q[3];
  assign dp_a     = {8'h00, x_acc_q[7:0]};
  assign dp_b     = {8'h00, y_acc_q[7:0]};
  assign busy     = (state_q != S_IDLE) && (state_q != S_FIN);
  assign done     = done_q;

endmodule

// File: tb/tb_dsa_interp_sequencer.sv
// Scoreboard bench for dsa_interp_sequencer with a byte-memory source and a
// 7-cycle bilinear datapath stand-in.
`timescale 1ns/1ps
module tb_dsa_interp_sequencer;
  localparam int DIM_W  = 10;
  localparam int ADDR_W = 20;

  logic              clk, rst, start;
  logic [DIM_W-1:0]  in_w, in_h, out_w, out_h;
  logic [15:0]       step;
  logic [ADDR_W-1:0] src_addr, dst_addr;
  logic              src_rd, dst_we, dp_start, dp_done, busy, done;
  logic [7:0]        src_data, dst_data, dp_pixel;
  logic [7:0]        dp_p00, dp_p01, dp_p10, dp_p11;
  logic [15:0]       dp_a, dp_b;

  dsa_interp_sequencer #(.DIM_W(DIM_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_w(in_w), .in_h(in_h), .out_w(out_w), .out_h(out_h), .step(step),
    .src_addr(src_addr), .src_rd(src_rd), .src_data(src_data),
    .dst_addr(dst_addr), .dst_we(dst_we), .dst_data(dst_data),
    .dp_start(dp_start), .dp_p00(dp_p00), .dp_p01(dp_p01), .dp_p10(dp_p10), .dp_p11(dp_p11),
    .dp_a(dp_a), .dp_b(dp_b), .dp_pixel(dp_pixel), .dp_done(dp_done),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [0:15];
  always @(posedge clk) if (src_rd) src_data <= mem[src_addr[3:0]];

  typedef struct { logic [ADDR_W-1:0] addr; logic [7:0] data; } wr_t;
  wr_t sb_q[$];
  wr_t mon_e;

  int checks = 0, failures = 0;
  int wr_cnt = 0, dps_cnt = 0, rd_cnt = 0, done_cnt = 0;
  bit chk_zero_frac = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] bilerp(input int p00, p01, p10, p11, a, b);
    int s;
    s = p00*(256-a)*(256-b) + p01*a*(256-b) + p10*(256-a)*b + p11*a*b;
    return 8'(s >> 16);
  endfunction

  // Datapath stand-in: done 7 cycles after launch, inputs latched for the stability check
  int dp_cnt;
  logic [79:0] dp_lat;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      dp_cnt <= 0; dp_done <= 1'b0; dp_pixel <= 8'h00; dp_lat <= '0;
    end else begin
      dp_done <= 1'b0;
      if (dp_start) begin
        dp_cnt <= 7;
        dp_lat <= {dp_p00, dp_p01, dp_p10, dp_p11, dp_a, dp_b};
      end else if (dp_cnt != 0) begin
        dp_cnt <= dp_cnt - 1;
        if (dp_cnt == 1) begin
          dp_done  <= 1'b1;
          dp_pixel <= bilerp(dp_p00, dp_p01, dp_p10, dp_p11, dp_a, dp_b);
        end
      end
    end
  end

  always @(negedge clk) if (rst) begin
    if (dst_we) begin
      wr_cnt++;
      if (sb_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_write addr=%0d data=%0d required=none", dst_addr, dst_data);
      end else begin
        mon_e = sb_q.pop_front();
        chk("dst_addr", dst_addr, mon_e.addr);
        chk("dst_data", dst_data, mon_e.data);
      end
    end
    if (dp_start) begin
      dps_cnt++;
      if (chk_zero_frac) chk("launch_frac_zero", {dp_a, dp_b}, 0);
    end
    if (src_rd) rd_cnt++;
    if (done) begin
      done_cnt++;
      chk("done_after_last_write", sb_q.size(), 0);
    end
    if (dp_cnt != 0 || dp_done)
      chk("dp_inputs_stable", {dp_p00, dp_p01, dp_p10, dp_p11, dp_a, dp_b} != dp_lat, 0);
  end

  task automatic push(input int addr, input int data);
    wr_t e;
    e.addr = ADDR_W'(addr);
    e.data = 8'(data);
    sb_q.push_back(e);
  endtask

  task automatic start_frame(input int iw, ih, ow, oh, input logic [15:0] st);
    @(negedge clk);
    in_w = DIM_W'(iw); in_h = DIM_W'(ih); out_w = DIM_W'(ow); out_h = DIM_W'(oh); step = st;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit ok = 0;
    for (int i = 0; i < 3000; i++) begin
      if (done) begin ok = 1; break; end
      @(negedge clk);
    end
    chk({name, "_timeout"}, ok, 1);
  endtask

  task automatic wait_dps(input int target);
    bit ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (dps_cnt >= target) begin ok = 1; break; end
    end
    chk("dp_start_timeout", ok, 1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_strobes"}, {src_rd, dst_we, dp_start, done, busy}, 0);
    chk({tag, "_addr"}, {src_addr, dst_addr}, 0);
    chk({tag, "_data"}, {dst_data, dp_p00, dp_p01, dp_p10, dp_p11}, 0);
    chk({tag, "_frac"}, {dp_a, dp_b}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  int exp1 [16] = '{100,110,120,120, 120,130,140,140, 140,150,160,160, 140,150,160,160};
  int exp2 [4]  = '{100,120,140,160};
  int w0, d0, r0, n0, c0;

  initial begin
    rst = 1'b0; start = 1'b0; src_data = 8'h00;
    in_w = '0; in_h = '0; out_w = '0; out_h = '0; step = '0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem[0] = 8'd100; mem[1] = 8'd120; mem[2] = 8'd140; mem[3] = 8'd160;
    #12;
    check_zero("reset");
    @(negedge clk); rst = 1'b1;

    // 2x2 source upscaled to 4x4 at step 0.5
    w0 = wr_cnt; d0 = dps_cnt; n0 = done_cnt;
    for (int i = 0; i < 16; i++) push(i, exp1[i]);
    start_frame(2, 2, 4, 4, 16'h0080);
    wait_done("frame4x4");
    @(negedge clk);
    chk("frame4x4_writes", wr_cnt - w0, 16);
    chk("frame4x4_launches", dps_cnt - d0, 16);
    chk("frame4x4_done_pulses", done_cnt - n0, 1);
    chk("done_one_cycle", done, 0);

    // unit step copy, fractions must be zero at each launch
    chk_zero_frac = 1;
    w0 = wr_cnt; d0 = dps_cnt;
    for (int i = 0; i < 4; i++) push(i, exp2[i]);
    start_frame(2, 2, 2, 2, 16'h0100);
    wait_done("copy2x2");
    @(negedge clk);
    chk("copy2x2_writes", wr_cnt - w0, 4);
    chk("copy2x2_launches", dps_cnt - d0, 4);

    // empty output frame
    w0 = wr_cnt; d0 = dps_cnt; r0 = rd_cnt; n0 = done_cnt;
    start_frame(2, 2, 0, 3, 16'h0100);
    chk("empty_done_early", done, 0);
    chk("empty_busy", busy, 0);
    @(negedge clk);
    chk("empty_done_2cyc", done, 1);
    @(negedge clk);
    chk("empty_no_reads", rd_cnt - r0, 0);
    chk("empty_no_writes", wr_cnt - w0, 0);
    chk("empty_no_launch", dps_cnt - d0, 0);
    chk("empty_done_pulses", done_cnt - n0, 1);

    // second start while waiting on the datapath is ignored
    w0 = wr_cnt; d0 = dps_cnt;
    for (int i = 0; i < 4; i++) push(i, exp2[i]);
    start_frame(2, 2, 2, 2, 16'h0100);
    wait_dps(d0 + 1);
    @(negedge clk);
    out_w = DIM_W'(4); out_h = DIM_W'(4); step = 16'h0080; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("restart_ignored");
    @(negedge clk);
    chk("restart_ignored_writes", wr_cnt - w0, 4);

    // reset during the third datapath wait
    w0 = wr_cnt; d0 = dps_cnt;
    push(0, 100); push(1, 120);
    start_frame(2, 2, 2, 2, 16'h0100);
    wait_dps(d0 + 3);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    #1 check_zero("abort");
    chk("abort_partial_writes", wr_cnt - w0, 2);
    chk("abort_sb_empty", sb_q.size(), 0);
    @(negedge clk); rst = 1'b1;
    w0 = wr_cnt;
    for (int i = 0; i < 4; i++) push(i, exp2[i]);
    start_frame(2, 2, 2, 2, 16'h0100);
    wait_done("after_abort");
    @(negedge clk);
    chk("after_abort_writes", wr_cnt - w0, 4);
    chk("final_sb_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dsa_interp_sequencer.md
Name: dsa_interp_sequencer

Overview:
- Initiator side of the dsa_datapath start/done interface; walks an output image in raster order.
- For each output pixel: computes the Q8.8 source coordinate, fetches the 4 neighbouring source pixels from a byte memory, and launches one dsa_datapath interpolation.
- Waits for the datapath's done, then writes its pixel_out to a destination memory.
- Top-level control for the sequential scaling mode.

Parameters:
- DIM_W, 10, width of all image dimensions and x/y counters.
- ADDR_W, 20, width of src_addr and dst_addr.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a frame when idle.
- in_w  in  DIM_W  source width in pixels; sampled at start.
- in_h  in  DIM_W  source height in pixels; sampled at start.
- out_w  in  DIM_W  output width; sampled at start.
- out_h  in  DIM_W  output height; sampled at start.
- step  in  16  Q8.8 source increment per output pixel; sampled at start.
- src_addr  out  ADDR_W  source byte address.
- src_rd  out  1  read strobe; data valid on src_data exactly 1 cycle later.
- src_data  in  8  source read data.
- dst_addr  out  ADDR_W  destination byte address.
- dst_we  out  1  destination write strobe, 1 cycle per output pixel.
- dst_data  out  8  destination write data.
- dp_start  out  1  one-cycle launch pulse to dsa_datapath.
- dp_p00  out  8  neighbour (xi, yi) to dsa_datapath, held stable from dp_start until dp_done.
- dp_p01  out  8  neighbour (xi+1, yi), held stable likewise.
- dp_p10  out  8  neighbour (xi, yi+1), held stable likewise.
- dp_p11  out  8  neighbour (xi+1, yi+1), held stable likewise.
- dp_a  out  16  horizontal fraction, {8'h00, x_acc[7:0]} (0x0080 = 0.5).
- dp_b  out  16  vertical fraction, {8'h00, y_acc[7:0]}.
- dp_pixel  in  8  dsa_datapath pixel_out.
- dp_done  in  1  dsa_datapath done.
- busy  out  1  high from the cycle after an accepted start until the frame completes.
- done  out  1  one-cycle pulse after the last write.

Behaviour:
- Reset (rst low, asynchronous): state IDLE.
  - All strobes (src_rd, dst_we, dp_start, done, busy) = 0.
  - All addresses, data, dp_* and accumulators = 0.
- Coordinates:
  - x_acc, y_acc: 18-bit Q10.8 accumulators.
  - x_acc clears at each row start and adds step after each pixel.
  - y_acc adds step after each row.
  - xi = x_acc[17:8] and yi = y_acc[17:8], each clamped to in_w-1 / in_h-1.
  - xi1 = min(xi+1, in_w-1); yi1 = min(yi+1, in_h-1).
  - Source address = row*in_w + col, computed with an unsigned multiply, truncated to ADDR_W.
- States:
  - IDLE: start=1 latches dimensions and step. If out_w==0 or out_h==0, go to FIN; else go to FETCH. start in any other state is ignored.
  - FETCH: 4 cycles, src_rd=1 each cycle, addresses in order (xi,yi), (xi1,yi), (xi,yi1), (xi1,yi1). Returned bytes captured 1 cycle later into dp_p00, dp_p01, dp_p10, dp_p11.
  - CAPT: 1 cycle capturing the last byte into dp_p11.
  - LAUNCH: dp_start=1 for exactly one cycle; dp_a and dp_b are valid in this same cycle.
  - WAIT_DP: hold all dp_* outputs until dp_done=1. dp_done arriving in the LAUNCH cycle itself is ignored. No timeout.
  - WRITE:
    - dst_we=1, dst_data=dp_pixel (registered at dp_done), dst_addr = running output index, starting at 0 and +1 per write.
    - Then advance x. If x_out==out_w-1: x_out=0, x_acc=0, y_out+1, y_acc+=step. If additionally y_out==out_h-1, go to FIN.
    - Otherwise go to FETCH.
  - FIN: done=1 for 1 cycle, busy=0, return to IDLE.
- Minimum per-pixel latency: 4 (FETCH) + 1 (CAPT) + 1 (LAUNCH) + datapath latency + 1 (WRITE).
- Exactly one transaction is outstanding to the datapath at any time.
- Reset mid-frame:
  - Immediate abort; all strobes drop in the same cycle; no partial write completes.
  - The next start begins a fresh frame at output index 0.

Test Plan:
- Source 2x2 [100,120;140,160], step=0x0080, out 4x4 -> 16 writes, addresses 0..15 in order.
  - dst[0]=100; dst[5] (a=b=0.5) = 130.
  - dst[15] (xi=1 clamped, all neighbours 160) = 160.
  - done pulses once, after the write to address 15.
- Same source, step=0x0100, out 2x2 -> dst = [100,120,140,160]; dp_a=dp_b=0 on every LAUNCH.
- out_w=0 -> no src_rd, no dst_we, no dp_start; done pulses 2 cycles after start.
- Second start pulse during WAIT_DP -> ignored; write count for the frame is unchanged.
- rst low during the third WAIT_DP -> all outputs 0 in the same cycle. A new start after release gives a complete frame beginning at dst_addr 0.
- Datapath model with a 7-cycle done delay -> dp_p00..dp_p11, dp_a and dp_b constant from dp_start through dp_done; exactly one dp_start per output pixel.
